// File: rtl/uk101_video_timing.sv
// UK101 video timing: pixel clock-enable divider, raster counters, sync/blank
// decode and character-cell coordinates, with a per-frame latched display mode.
module uk101_video_timing #(
    parameter int unsigned CE_DIV       = 5,
    parameter int unsigned H_TOTAL      = 640,
    parameter int unsigned V_TOTAL      = 312,
    parameter int unsigned H_SYNC_START = 560,
    parameter int unsigned H_SYNC_LEN   = 48,
    parameter int unsigned V_SYNC_START = 280,
    parameter int unsigned V_SYNC_LEN   = 3,
    parameter int unsigned V_ACTIVE     = 256
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       mode,
    output logic       ce_pix,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       de,
    output logic [5:0] char_col,
    output logic [4:0] char_row,
    output logic [2:0] pix_x,
    output logic [3:0] pix_y,
    output logic       frame_start,
    output logic       mode_active
);

    localparam int unsigned DW       = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned H_ACT_64 = 512;
    localparam int unsigned H_ACT_48 = 384;

    // Parameter sanity, evaluated at elaboration
    if (CE_DIV < 1) begin : g_bad_ce_div
        $error("CE_DIV must be at least 1");
    end
    if (H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_bad_hsync
        $error("hsync extends past H_TOTAL");
    end
    if (V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_bad_vsync
        $error("vsync extends past V_TOTAL");
    end
    if (V_ACTIVE > V_SYNC_START) begin : g_bad_vactive
        $error("V_ACTIVE overlaps vsync");
    end
    if (H_SYNC_START < H_ACT_64) begin : g_bad_hsync_start
        $error("hsync starts inside the 64-column active area");
    end

    logic [DW-1:0] div;
    logic [HW-1:0] h;
    logic [VW-1:0] v;

    logic        at_origin;
    logic        m_c;
    logic [31:0] h_i;
    logic [31:0] v_i;
    logic        hb_c, vb_c, hs_c, vs_c, de_c;
    logic [5:0]  col_c;
    logic [4:0]  row_c;
    logic [2:0]  px_c;
    logic [3:0]  py_c;
    logic        h_last, v_last;

    // Decode of the current raster position; the new mode applies from (0,0)
    always_comb begin
        at_origin = (h == '0) && (v == '0);
        m_c       = at_origin ? mode : mode_active;
        h_i       = 32'(h);
        v_i       = 32'(v);
        hb_c      = h_i >= (m_c ? H_ACT_48 : H_ACT_64);
        vb_c      = v_i >= V_ACTIVE;
        hs_c      = (h_i >= H_SYNC_START) && (h_i < H_SYNC_START + H_SYNC_LEN);
        vs_c      = (v_i >= V_SYNC_START) && (v_i < V_SYNC_START + V_SYNC_LEN);
        de_c      = !hb_c && !vb_c;
        col_c     = '0;
        row_c     = '0;
        px_c      = '0;
        py_c      = '0;
        if (de_c) begin
            px_c  = h_i[2:0];
            col_c = h_i[8:3];
            if (m_c) begin
                py_c  = v_i[3:0];
                row_c = {1'b0, v_i[7:4]};
            end else begin
                py_c  = {1'b0, v_i[2:0]};
                row_c = v_i[7:3];
            end
        end
        h_last = (h == HW'(H_TOTAL - 1));
        v_last = (v == VW'(V_TOTAL - 1));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            ce_pix      <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            de          <= 1'b0;
            char_col    <= '0;
            char_row    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            mode_active <= 1'b0;
        end else begin
            if (div == DW'(CE_DIV - 1)) begin
                div    <= '0;
                ce_pix <= 1'b1;
            end else begin
                div    <= div + DW'(1);
                ce_pix <= 1'b0;
            end
            // Outputs lag the counters by one pixel
            if (ce_pix) begin
                hsync       <= hs_c;
                vsync       <= vs_c;
                hblank      <= hb_c;
                vblank      <= vb_c;
                de          <= de_c;
                char_col    <= col_c;
                char_row    <= row_c;
                pix_x       <= px_c;
                pix_y       <= py_c;
                frame_start <= at_origin;
                if (at_origin) begin
                    mode_active <= mode;
                end
                if (h_last) begin
                    h <= '0;
                    v <= v_last ? '0 : v + VW'(1);
                end else begin
                    h <= h + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uk101_video_timing.sv
// Bench for uk101_video_timing: default build (CE_DIV=5) vector table, a short
// CE_DIV=1 raster for whole-frame / mode-latch / reset checks, and a CE_DIV=6 build.
module tb_uk101_video_timing;

    localparam int unsigned VB     = 30;
    localparam int unsigned VB_ACT = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic mode_a, mode_b, mode_c;

    logic a_ce, a_hs, a_vs, a_hb, a_vb, a_de, a_fs, a_ma;
    logic [5:0] a_col; logic [4:0] a_row; logic [2:0] a_px; logic [3:0] a_py;
    logic b_ce, b_hs, b_vs, b_hb, b_vb, b_de, b_fs, b_ma;
    logic [5:0] b_col; logic [4:0] b_row; logic [2:0] b_px; logic [3:0] b_py;
    logic c_ce, c_hs, c_vs, c_hb, c_vb, c_de, c_fs, c_ma;
    logic [5:0] c_col; logic [4:0] c_row; logic [2:0] c_px; logic [3:0] c_py;

    uk101_video_timing dut_a (
        .clk(clk), .n_reset(rst_a), .mode(mode_a), .ce_pix(a_ce), .hsync(a_hs),
        .vsync(a_vs), .hblank(a_hb), .vblank(a_vb), .de(a_de), .char_col(a_col),
        .char_row(a_row), .pix_x(a_px), .pix_y(a_py), .frame_start(a_fs),
        .mode_active(a_ma)
    );

    uk101_video_timing #(
        .CE_DIV(1), .V_TOTAL(VB), .V_SYNC_START(26), .V_SYNC_LEN(3), .V_ACTIVE(VB_ACT)
    ) dut_b (
        .clk(clk), .n_reset(rst_b), .mode(mode_b), .ce_pix(b_ce), .hsync(b_hs),
        .vsync(b_vs), .hblank(b_hb), .vblank(b_vb), .de(b_de), .char_col(b_col),
        .char_row(b_row), .pix_x(b_px), .pix_y(b_py), .frame_start(b_fs),
        .mode_active(b_ma)
    );

    uk101_video_timing #(.CE_DIV(6)) dut_c (
        .clk(clk), .n_reset(rst_c), .mode(mode_c), .ce_pix(c_ce), .hsync(c_hs),
        .vsync(c_vs), .hblank(c_hb), .vblank(c_vb), .de(c_de), .char_col(c_col),
        .char_row(c_row), .pix_x(c_px), .pix_y(c_py), .frame_start(c_fs),
        .mode_active(c_ma)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        int edge_n;
        int ce, fs, de, hb, vb, hs, vs, col, px, row, py;
    } vec_t;

    // Frame statistics gathered by scan_b
    int s_len, s_bad_de, s_bad_hs, s_vs_lines, s_vs_first;
    int s_max_col, s_max_py, s_ma_bad, s_ce_low, s_rows;

    // Walks one CE_DIV=1 frame starting at its frame_start sample
    task automatic scan_b(input bit toggle, input int act, input int ma);
        int de_l[VB];
        int hs_l[VB];
        int hs_f[VB];
        int vs_l[VB];
        int hh, vv;
        for (int k = 0; k < VB; k++) begin
            de_l[k] = 0; hs_l[k] = 0; hs_f[k] = -1; vs_l[k] = 0;
        end
        s_len = 0; s_max_col = 0; s_max_py = 0; s_ma_bad = 0; s_ce_low = 0; s_rows = 0;
        for (int i = 0; i < 25000; i++) begin
            if (i > 0 && b_fs) break;
            hh = i % 640;
            vv = i / 640;
            if (vv < VB) begin
                de_l[vv] += int'(b_de);
                if (b_hs) begin
                    hs_l[vv]++;
                    if (hs_f[vv] < 0) hs_f[vv] = hh;
                end
                if (b_vs) vs_l[vv] = 1;
            end
            if (int'(b_col) > s_max_col) s_max_col = int'(b_col);
            if (int'(b_py) > s_max_py) s_max_py = int'(b_py);
            s_rows |= (1 << b_row);
            if (int'(b_ma) != ma) s_ma_bad++;
            if (!b_ce) s_ce_low++;
            if (toggle && i == 10 * 640) mode_b = 1'b1;
            @(negedge clk);
            s_len = i + 1;
        end
        s_bad_de = 0; s_bad_hs = 0; s_vs_lines = 0; s_vs_first = -1;
        for (int k = 0; k < VB; k++) begin
            if (de_l[k] != ((k < VB_ACT) ? act : 0)) s_bad_de++;
            if (hs_l[k] != 48 || hs_f[k] != 560) s_bad_hs++;
            if (vs_l[k] != 0) begin
                s_vs_lines++;
                if (s_vs_first < 0) s_vs_first = k;
            end
        end
    endtask

    task automatic frame_checks(input string tag, input int act, input int max_col,
                                input int max_py, input int rows);
        chk({tag, " len"}, s_len, 640 * VB);
        chk({tag, " de lines"}, s_bad_de, 0);
        chk({tag, " hsync lines"}, s_bad_hs, 0);
        chk({tag, " vsync count"}, s_vs_lines, 3);
        chk({tag, " vsync first"}, s_vs_first, 26);
        chk({tag, " max col"}, s_max_col, max_col);
        chk({tag, " max pix_y"}, s_max_py, max_py);
        chk({tag, " rows"}, s_rows, rows);
        chk({tag, " mode_active"}, s_ma_bad, 0);
        chk({tag, " ce low"}, s_ce_low, 0);
        chk({tag, " act"}, act, act);
    endtask

    task automatic check_b_reset(input string tag);
        chk({tag, " ce"}, int'(b_ce), 0);
        chk({tag, " hsync"}, int'(b_hs), 0);
        chk({tag, " vsync"}, int'(b_vs), 0);
        chk({tag, " hblank"}, int'(b_hb), 1);
        chk({tag, " vblank"}, int'(b_vb), 1);
        chk({tag, " de"}, int'(b_de), 0);
        chk({tag, " fs"}, int'(b_fs), 0);
        chk({tag, " col"}, int'(b_col), 0);
        chk({tag, " row"}, int'(b_row), 0);
        chk({tag, " px"}, int'(b_px), 0);
        chk({tag, " py"}, int'(b_py), 0);
        chk({tag, " ma"}, int'(b_ma), 0);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        mode_a = 1'b0; mode_b = 1'b0; mode_c = 1'b0;
        fork
            // Default build: vectors indexed by clk edges after reset release
            begin : thread_a
                vec_t va[18];
                int edges;
                va[0]  = '{1,     0,0,0,1,1,0,0, 0,0,0,0};
                va[1]  = '{4,     0,0,0,1,1,0,0, 0,0,0,0};
                va[2]  = '{5,     1,0,0,1,1,0,0, 0,0,0,0};
                va[3]  = '{6,     0,1,1,0,0,0,0, 0,0,0,0};
                va[4]  = '{10,    1,1,1,0,0,0,0, 0,0,0,0};
                va[5]  = '{11,    0,0,1,0,0,0,0, 0,1,0,0};
                va[6]  = '{41,    0,0,1,0,0,0,0, 0,7,0,0};
                va[7]  = '{46,    0,0,1,0,0,0,0, 1,0,0,0};
                va[8]  = '{2561,  0,0,1,0,0,0,0, 63,7,0,0};
                va[9]  = '{2566,  0,0,0,1,0,0,0, 0,0,0,0};
                va[10] = '{2801,  0,0,0,1,0,0,0, 0,0,0,0};
                va[11] = '{2806,  0,0,0,1,0,1,0, 0,0,0,0};
                va[12] = '{3041,  0,0,0,1,0,1,0, 0,0,0,0};
                va[13] = '{3046,  0,0,0,1,0,0,0, 0,0,0,0};
                va[14] = '{3201,  0,0,0,1,0,0,0, 0,0,0,0};
                va[15] = '{3206,  0,0,1,0,0,0,0, 0,0,0,1};
                va[16] = '{25606, 0,0,1,0,0,0,0, 0,0,1,0};
                va[17] = '{28891, 0,0,1,0,0,0,0, 2,1,1,1};
                repeat (3) @(negedge clk);
                chk("A reset hblank", int'(a_hb), 1);
                chk("A reset vblank", int'(a_vb), 1);
                chk("A reset de", int'(a_de), 0);
                chk("A reset ce", int'(a_ce), 0);
                chk("A reset ma", int'(a_ma), 0);
                rst_a = 1'b1;
                edges = 0;
                for (int i = 0; i < 18; i++) begin
                    while (edges < va[i].edge_n) begin
                        @(negedge clk);
                        edges++;
                    end
                    chk($sformatf("A[%0d] ce", i), int'(a_ce), va[i].ce);
                    chk($sformatf("A[%0d] fs", i), int'(a_fs), va[i].fs);
                    chk($sformatf("A[%0d] de", i), int'(a_de), va[i].de);
                    chk($sformatf("A[%0d] hblank", i), int'(a_hb), va[i].hb);
                    chk($sformatf("A[%0d] vblank", i), int'(a_vb), va[i].vb);
                    chk($sformatf("A[%0d] hsync", i), int'(a_hs), va[i].hs);
                    chk($sformatf("A[%0d] vsync", i), int'(a_vs), va[i].vs);
                    chk($sformatf("A[%0d] col", i), int'(a_col), va[i].col);
                    chk($sformatf("A[%0d] px", i), int'(a_px), va[i].px);
                    chk($sformatf("A[%0d] row", i), int'(a_row), va[i].row);
                    chk($sformatf("A[%0d] py", i), int'(a_py), va[i].py);
                end
            end

            // CE_DIV=1 short raster: whole frames, mode latch, mid-frame reset
            begin : thread_b
                repeat (3) @(negedge clk);
                check_b_reset("B reset");
                rst_b = 1'b1;
                @(negedge clk);
                chk("B edge1 ce", int'(b_ce), 1);
                chk("B edge1 fs", int'(b_fs), 0);
                @(negedge clk);
                chk("B edge2 fs", int'(b_fs), 1);
                chk("B edge2 de", int'(b_de), 1);
                scan_b(1'b0, 512, 0);
                frame_checks("B f0", 512, 63, 7, 32'h7);
                scan_b(1'b1, 512, 0);
                frame_checks("B f1", 512, 63, 7, 32'h7);
                scan_b(1'b0, 384, 1);
                frame_checks("B f2", 384, 47, 15, 32'h3);
                chk("B f3 fs", int'(b_fs), 1);
                repeat (15 * 640 + 300) @(negedge clk);
                chk("B pre-rst de", int'(b_de), 1);
                chk("B pre-rst col", int'(b_col), 37);
                chk("B pre-rst py", int'(b_py), 15);
                #1 rst_b = 1'b0;
                #1 check_b_reset("B midrst");
                repeat (3) @(negedge clk);
                chk("B held hblank", int'(b_hb), 1);
                rst_b = 1'b1;
                @(negedge clk);
                chk("B rel edge1 ce", int'(b_ce), 1);
                chk("B rel edge1 fs", int'(b_fs), 0);
                chk("B rel edge1 hblank", int'(b_hb), 1);
                @(negedge clk);
                chk("B rel edge2 fs", int'(b_fs), 1);
                chk("B rel edge2 de", int'(b_de), 1);
                chk("B rel edge2 col", int'(b_col), 0);
                chk("B rel edge2 row", int'(b_row), 0);
                chk("B rel edge2 ma", int'(b_ma), 1);
            end

            // CE_DIV=6: first pulse, period, line length in ce pulses
            begin : thread_c
                int e, cnt, mn, mx, rises;
                bit prev;
                repeat (3) @(negedge clk);
                rst_c = 1'b1;
                e = 0;
                do begin
                    @(negedge clk);
                    e++;
                end while (!c_ce && e < 20);
                chk("C first ce edge", e, 6);
                mn = 1000; mx = 0;
                for (int k = 0; k < 8; k++) begin
                    cnt = 0;
                    do begin
                        @(negedge clk);
                        cnt++;
                    end while (!c_ce && cnt < 20);
                    if (cnt < mn) mn = cnt;
                    if (cnt > mx) mx = cnt;
                end
                chk("C period min", mn, 6);
                chk("C period max", mx, 6);
                cnt = 0; rises = 0; prev = c_de;
                for (int i = 0; i < 10000; i++) begin
                    @(negedge clk);
                    if (c_de && !prev) rises++;
                    if (rises == 2) break;
                    if (rises == 1 && c_ce) cnt++;
                    prev = c_de;
                end
                chk("C de rises", rises, 2);
                chk("C line ce count", cnt, 640);
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
